// File: rtl/hls_fu_arbiter_if.sv
// Handshake bundle between NREQ HLSM requesters and the shared functional-unit arbiter.
// Requesters drive the master side; the arbiter sits on the slave side.
interface hls_fu_arbiter_if #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4
);
  logic [NREQ-1:0]           Req;
  logic [3*NREQ-1:0]         Op;
  logic [DATAWIDTH*NREQ-1:0] A;
  logic [DATAWIDTH*NREQ-1:0] B;
  logic [NREQ-1:0]           Grant;
  logic [NREQ-1:0]           Ack;
  logic [DATAWIDTH-1:0]      Result;
  logic                      Busy;

  modport master (
    output Req, Op, A, B,
    input  Grant, Ack, Result, Busy
  );

  modport slave (
    input  Req, Op, A, B,
    output Grant, Ack, Result, Busy
  );
endinterface

// File: rtl/hls_fu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle signed ALU among NREQ HLSM requesters.
// One operation in flight; operands are latched at grant and the result is returned with a one-cycle Ack.
module hls_fu_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4,
  parameter int LAT       = 2
) (
  input logic             Clk,
  input logic             Rst,
  hls_fu_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(DATAWIDTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [PW-1:0]         ptr;
  logic [CW-1:0]         cnt;
  logic [2:0]            opReg;
  logic [DATAWIDTH-1:0]  aReg;
  logic [DATAWIDTH-1:0]  bReg;
  logic [NREQ-1:0]       grantReg;
  logic [NREQ-1:0]       ackReg;
  logic [DATAWIDTH-1:0]  resultReg;
  logic                  busyReg;

  logic                  found;
  logic [PW-1:0]         pick;
  logic [NREQ-1:0]       pickHot;
  logic [2:0]            pickOp;
  logic [DATAWIDTH-1:0]  pickA;
  logic [DATAWIDTH-1:0]  pickB;
  int                    bestRank;
  int                    rank;

  // The winner is the pending requester with the smallest distance from the pointer, mod NREQ.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pickHot  = '0;
    pickOp   = '0;
    pickA    = '0;
    pickB    = '0;
    bestRank = NREQ;
    rank     = 0;
    for (int i = 0; i < NREQ; i++) begin
      rank = (i + NREQ - int'(ptr)) % NREQ;
      if (bus.Req[i] && rank < bestRank) begin
        bestRank   = rank;
        found      = 1'b1;
        pick       = PW'(i);
        pickHot    = '0;
        pickHot[i] = 1'b1;
        pickOp     = bus.Op[3*i +: 3];
        pickA      = bus.A[DATAWIDTH*i +: DATAWIDTH];
        pickB      = bus.B[DATAWIDTH*i +: DATAWIDTH];
      end
    end
  end

  function automatic logic [DATAWIDTH-1:0] alu(
    input logic [2:0]           op,
    input logic [DATAWIDTH-1:0] a,
    input logic [DATAWIDTH-1:0] b
  );
    logic [DATAWIDTH-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = {{(DATAWIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      3'd3:    r = {{(DATAWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd4:    r = {{(DATAWIDTH-1){1'b0}}, (a == b)};
      3'd5:    r = a << b[SW-1:0];
      3'd6:    r = $unsigned($signed(a) >>> b[SW-1:0]);
      default: r = a;
    endcase
    return r;
  endfunction

  // IDLE always burns one cycle, so a requester just served cannot be re-granted straight from RESP.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      grantReg  <= '0;
      ackReg    <= '0;
      resultReg <= '0;
      busyReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            opReg    <= pickOp;
            aReg     <= pickA;
            bReg     <= pickB;
            grantReg <= pickHot;
            ptr      <= (pick == PW'(NREQ-1)) ? '0 : pick + 1'b1;
            cnt      <= CW'(LAT-1);
            busyReg  <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            resultReg <= alu(opReg, aReg, bReg);
            ackReg    <= grantReg;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          ackReg   <= '0;
          grantReg <= '0;
          busyReg  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Grant  = grantReg;
  assign bus.Ack    = ackReg;
  assign bus.Result = resultReg;
  assign bus.Busy   = busyReg;

endmodule
